is_uart_echo_buf: RTL and testbench
===================================

Name: is_uart_echo_buf

Overview:
- Sits between the RX and TX paths of the UART controller.
- Consumes 10-bit received frames (rx_data_en / rx_data_t) and checks the start and stop bits.
- Pushes good data bytes into a FIFO, then drains the FIFO into the TX FSM over its rdy_t/rdy_r handshake (echo / loopback path).
- Exposes FIFO level and sticky error status for debug LEDs.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- rx_data_en_i  input  1  one-cycle strobe: rx_data_t_i holds a new frame
- rx_data_t_i  input  10  frame: [0]=start, [8:1]=data LSB-first, [9]=stop
- echo_en_i  input  1  1 = drain FIFO to TX; 0 = hold FIFO contents
- err_clr_i  input  1  clears sticky flags and the error counter
- tx_rdy_r_i  input  1  TX FSM idle, can accept a byte
- tx_rdy_t_o  output  1  byte offered on tx_data_r_o
- tx_data_r_o  output  8  byte to transmit
- fifo_cnt_o  output  CW  current occupancy, 0..DEPTH
- fifo_full_o  output  1  occupancy == DEPTH
- fifo_empty_o  output  1  occupancy == 0
- frame_err_o  output  1  sticky: a frame had a bad start or stop bit
- ovf_o  output  1  sticky: a good byte was dropped because the FIFO was full
- err_cnt_o  output  8  saturating count of bad frames plus dropped bytes

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - read pointer, write pointer and count = 0
  - tx_rdy_t_o=0, tx_data_r_o=8'h00, fifo_empty_o=1, fifo_full_o=0
  - frame_err_o=0, ovf_o=0, err_cnt_o=0
  - FSM = IDLE
  - Reset mid-transfer aborts the offer; the byte is lost; FIFO storage contents are don't-care.
- Frame check, on a cycle with rx_data_en_i=1:
  - good = (rx_data_t_i[0]==0) && (rx_data_t_i[9]==1)
  - Bad frame: not pushed; frame_err_o<=1; err_cnt_o increments.
- Push: a good frame pushes rx_data_t_i[8:1] at the write pointer.
  - Write is legal if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped; ovf_o<=1; err_cnt_o increments.
- err_cnt_o saturates at 8'hFF.
- Bad frame or drop coinciding with err_clr_i: the clear wins and the event is lost (flags 0, count 0).
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is updated as +1 on push only, -1 on pop only, unchanged on push+pop.
- fifo_cnt_o, fifo_full_o and fifo_empty_o are registered and reflect the state after the edge; 1-cycle latency from push to fifo_empty_o=0.
- TX FSM:
  - IDLE: if echo_en_i && !empty, pop the head into tx_data_r_o, then go to OFFER. The pop is this cycle.
  - OFFER: tx_rdy_t_o=1 and tx_data_r_o stable. When tx_rdy_r_i=1 the transfer completes; go to GAP with tx_rdy_t_o<=0.
  - GAP: one cycle with tx_rdy_t_o=0, so the TX FSM sees a deasserted request and drops tx_rdy_r_i; then go to IDLE.
  - Dropping echo_en_i during OFFER does not withdraw the offered byte.
  - Minimum spacing between handshakes is 3 cycles (IDLE, OFFER, GAP).
- Latency: a good frame on cycle N gives tx_rdy_t_o=1 at cycle N+2 (FIFO previously empty, FSM in IDLE, echo_en_i=1).
- Ordering: strict FIFO; bytes exit in arrival order.

Test Plan:
- Reset, then one good frame 10'b1_01000001_0 (byte 8'h41) with echo_en_i=1 and tx_rdy_r_i=1 -> fifo_cnt_o 1 for one cycle; tx_rdy_t_o=1 at N+2 with tx_data_r_o=8'h41; fifo_empty_o=1 afterwards.
- Bad frames 10'b0_00000000_0 (stop=0) and 10'b1_11111111_1 (start=1) -> nothing pushed; frame_err_o=1; err_cnt_o=2; err_clr_i pulse -> both 0.
- echo_en_i=0, push 17 good bytes 8'h00..8'h10 with DEPTH=16 -> fifo_full_o=1, fifo_cnt_o=16, ovf_o=1, err_cnt_o=1. Then echo_en_i=1 -> 8'h00..8'h0F emerge in order; 8'h10 never appears.
- FIFO full, echo_en_i=1, new good byte arriving in the same cycle as the IDLE pop -> byte accepted, fifo_cnt_o stays 16, ovf_o stays 0.
- tx_rdy_r_i held 0 for 50 cycles during OFFER -> tx_rdy_t_o stays 1 and tx_data_r_o is unchanged; handshake on release; GAP cycle has tx_rdy_t_o=0.
- rst_i asserted while in OFFER with 5 bytes queued -> next cycle tx_rdy_t_o=0, fifo_cnt_o=0, fifo_empty_o=1, all flags 0.
- Send 300 bad frames -> err_cnt_o saturates at 8'hFF.

Source files
------------

// File: rtl/is_uart_echo_buf.sv
// UART echo buffer: checks received frames and queues good bytes in a FIFO.
// The FIFO is drained into the TX FSM over a ready/request handshake.
// Sticky error flags and a saturating error counter are provided for debug.
module is_uart_echo_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_data_en_i,
  input  logic [9:0]    rx_data_t_i,
  input  logic          echo_en_i,
  input  logic          err_clr_i,
  input  logic          tx_rdy_r_i,
  output logic          tx_rdy_t_o,
  output logic [7:0]    tx_data_r_o,
  output logic [CW-1:0] fifo_cnt_o,
  output logic          fifo_full_o,
  output logic          fifo_empty_o,
  output logic          frame_err_o,
  output logic          ovf_o,
  output logic [7:0]    err_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StOffer, StGap} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_data_q;
  logic            frame_err_q, frame_err_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      mem [DEPTH];

  logic frame_good, bad_frame, push_req, push, pop, drop, empty, full;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign frame_good = ~rx_data_t_i[0] & rx_data_t_i[9];
  assign bad_frame  = rx_data_en_i & ~frame_good;
  assign push_req   = rx_data_en_i & frame_good;
  assign pop        = (state_q == StIdle) & echo_en_i & ~empty;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & ~push;

  // TX handshake next-state: IDLE pops, OFFER holds until accepted, GAP drops the request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StOffer;
      StOffer: if (tx_rdy_r_i) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Occupancy and error bookkeeping next-state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    frame_err_d = frame_err_q;
    ovf_d       = ovf_q;
    err_cnt_d   = err_cnt_q;
    // Clear wins over a coincident error event.
    if (err_clr_i) begin
      frame_err_d = 1'b0;
      ovf_d       = 1'b0;
      err_cnt_d   = 8'h00;
    end else begin
      if (bad_frame) frame_err_d = 1'b1;
      if (drop)      ovf_d       = 1'b1;
      if ((bad_frame | drop) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  // Control state, pointers, output byte and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      tx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      err_cnt_q   <= err_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem[rd_ptr_q];
      end
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= rx_data_t_i[8:1];
  end

  assign tx_rdy_t_o   = (state_q == StOffer);
  assign tx_data_r_o  = tx_data_q;
  assign fifo_cnt_o   = cnt_q;
  assign fifo_full_o  = full;
  assign fifo_empty_o = empty;
  assign frame_err_o  = frame_err_q;
  assign ovf_o        = ovf_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_is_uart_echo_buf.sv
// Directed bench for is_uart_echo_buf: vector table plus multi-cycle sequences.
module tb_is_uart_echo_buf;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_data_en_i = 1'b0;
  logic [9:0]    rx_data_t_i = '0;
  logic          echo_en_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic          tx_rdy_r_i = 1'b0;
  logic          tx_rdy_t_o;
  logic [7:0]    tx_data_r_o;
  logic [CW-1:0] fifo_cnt_o;
  logic          fifo_full_o;
  logic          fifo_empty_o;
  logic          frame_err_o;
  logic          ovf_o;
  logic [7:0]    err_cnt_o;

  is_uart_echo_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_data_en_i(rx_data_en_i),
    .rx_data_t_i (rx_data_t_i),
    .echo_en_i   (echo_en_i),
    .err_clr_i   (err_clr_i),
    .tx_rdy_r_i  (tx_rdy_r_i),
    .tx_rdy_t_o  (tx_rdy_t_o),
    .tx_data_r_o (tx_data_r_o),
    .fifo_cnt_o  (fifo_cnt_o),
    .fifo_full_o (fifo_full_o),
    .fifo_empty_o(fifo_empty_o),
    .frame_err_o (frame_err_o),
    .ovf_o       (ovf_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rx_en;
    logic [9:0] rx;
    logic       echo;
    logic       clr;
    logic       rdy_r;
    logic       rdy_t;
    logic [7:0] data;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       fe;
    logic       ovf;
    logic [7:0] ec;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    rx_data_en_i = 1'b0;
    err_clr_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  vec_t tbl [9];
  logic [7:0] q [$];

  initial begin
    // rst rx_en rx echo clr rdy_r | rdy_t data cnt empty full fe ovf ec
    tbl[0] = '{1, 0, 10'h000, 1, 0, 1, 0, 8'h00, 5'd0, 1, 0, 0, 0, 8'd0};
    tbl[1] = '{0, 1, 10'b1_01000001_0, 1, 0, 1, 0, 8'h00, 5'd1, 0, 0, 0, 0, 8'd0};
    tbl[2] = '{0, 0, 10'h000, 1, 0, 1, 1, 8'h41, 5'd0, 1, 0, 0, 0, 8'd0};
    tbl[3] = '{0, 0, 10'h000, 1, 0, 1, 0, 8'h41, 5'd0, 1, 0, 0, 0, 8'd0};
    tbl[4] = '{0, 0, 10'h000, 1, 0, 1, 0, 8'h41, 5'd0, 1, 0, 0, 0, 8'd0};
    tbl[5] = '{0, 1, 10'b0_00000000_0, 1, 0, 1, 0, 8'h41, 5'd0, 1, 0, 1, 0, 8'd1};
    tbl[6] = '{0, 1, 10'b1_11111111_1, 1, 0, 1, 0, 8'h41, 5'd0, 1, 0, 1, 0, 8'd2};
    tbl[7] = '{0, 0, 10'h000, 1, 1, 1, 0, 8'h41, 5'd0, 1, 0, 0, 0, 8'd0};
    tbl[8] = '{0, 1, 10'b0_00000000_0, 1, 1, 1, 0, 8'h41, 5'd0, 1, 0, 0, 0, 8'd0};

    #1;
    for (int i = 0; i < 9; i++) begin
      rst_i        = tbl[i].rst;
      rx_data_en_i = tbl[i].rx_en;
      rx_data_t_i  = tbl[i].rx;
      echo_en_i    = tbl[i].echo;
      err_clr_i    = tbl[i].clr;
      tx_rdy_r_i   = tbl[i].rdy_r;
      tick();
      check($sformatf("v%0d.rdy_t", i), 32'(tx_rdy_t_o), 32'(tbl[i].rdy_t));
      check($sformatf("v%0d.data", i), 32'(tx_data_r_o), 32'(tbl[i].data));
      check($sformatf("v%0d.cnt", i), 32'(fifo_cnt_o), 32'(tbl[i].cnt));
      check($sformatf("v%0d.empty", i), 32'(fifo_empty_o), 32'(tbl[i].empty));
      check($sformatf("v%0d.full", i), 32'(fifo_full_o), 32'(tbl[i].full));
      check($sformatf("v%0d.frame_err", i), 32'(frame_err_o), 32'(tbl[i].fe));
      check($sformatf("v%0d.ovf", i), 32'(ovf_o), 32'(tbl[i].ovf));
      check($sformatf("v%0d.err_cnt", i), 32'(err_cnt_o), 32'(tbl[i].ec));
    end
    rx_data_en_i = 1'b0;
    err_clr_i    = 1'b0;

    // Overflow: 17 bytes into a 16-deep FIFO with echo off, then drain in order.
    do_reset();
    echo_en_i  = 1'b0;
    tx_rdy_r_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data_en_i = 1'b1;
      rx_data_t_i  = frame(8'(i));
      tick();
    end
    rx_data_en_i = 1'b0;
    check("ovf.cnt", 32'(fifo_cnt_o), 32'd16);
    check("ovf.full", 32'(fifo_full_o), 32'd1);
    check("ovf.ovf", 32'(ovf_o), 32'd1);
    check("ovf.err_cnt", 32'(err_cnt_o), 32'd1);
    check("ovf.frame_err", 32'(frame_err_o), 32'd0);
    echo_en_i = 1'b1;
    q.delete();
    for (int c = 0; c < 80; c++) begin
      tick();
      if (tx_rdy_t_o) q.push_back(tx_data_r_o);
    end
    check("drain.count", 32'(q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < q.size()) check($sformatf("drain.byte%0d", i), 32'(q[i]), 32'(i));
    end
    check("drain.empty", 32'(fifo_empty_o), 32'd1);
    check("drain.rdy_t", 32'(tx_rdy_t_o), 32'd0);

    // Full FIFO: push coinciding with the IDLE pop is accepted.
    do_reset();
    echo_en_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx_data_en_i = 1'b1;
      rx_data_t_i  = frame(8'h20 + 8'(i));
      tick();
    end
    check("pp.prefull", 32'(fifo_full_o), 32'd1);
    echo_en_i    = 1'b1;
    tx_rdy_r_i   = 1'b0;
    rx_data_en_i = 1'b1;
    rx_data_t_i  = frame(8'h30);
    tick();
    rx_data_en_i = 1'b0;
    check("pp.rdy_t", 32'(tx_rdy_t_o), 32'd1);
    check("pp.data", 32'(tx_data_r_o), 32'h20);
    check("pp.cnt", 32'(fifo_cnt_o), 32'd16);
    check("pp.ovf", 32'(ovf_o), 32'd0);
    check("pp.err_cnt", 32'(err_cnt_o), 32'd0);

    // Stalled offer: TX not ready for 50 cycles, echo dropped midway.
    for (int c = 0; c < 50; c++) begin
      if (c == 25) echo_en_i = 1'b0;
      tick();
      check($sformatf("stall%0d.rdy_t", c), 32'(tx_rdy_t_o), 32'd1);
      check($sformatf("stall%0d.data", c), 32'(tx_data_r_o), 32'h20);
    end
    check("stall.cnt", 32'(fifo_cnt_o), 32'd16);
    echo_en_i  = 1'b1;
    tx_rdy_r_i = 1'b1;
    tick();
    check("gap.rdy_t", 32'(tx_rdy_t_o), 32'd0);
    check("gap.data", 32'(tx_data_r_o), 32'h20);
    tick();
    check("idle.rdy_t", 32'(tx_rdy_t_o), 32'd0);
    tick();
    check("next.rdy_t", 32'(tx_rdy_t_o), 32'd1);
    check("next.data", 32'(tx_data_r_o), 32'h21);
    check("next.cnt", 32'(fifo_cnt_o), 32'd15);

    // Reset during OFFER with 5 bytes queued and a sticky flag set.
    do_reset();
    echo_en_i  = 1'b0;
    tx_rdy_r_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_data_en_i = 1'b1;
      rx_data_t_i  = frame(8'h50 + 8'(i));
      tick();
    end
    rx_data_t_i = 10'h000;
    tick();
    rx_data_en_i = 1'b0;
    echo_en_i    = 1'b1;
    tick();
    check("rstoff.rdy_t", 32'(tx_rdy_t_o), 32'd1);
    check("rstoff.data", 32'(tx_data_r_o), 32'h50);
    check("rstoff.cnt", 32'(fifo_cnt_o), 32'd5);
    check("rstoff.fe", 32'(frame_err_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i     = 1'b0;
    echo_en_i = 1'b0;
    check("rst.rdy_t", 32'(tx_rdy_t_o), 32'd0);
    check("rst.data", 32'(tx_data_r_o), 32'h00);
    check("rst.cnt", 32'(fifo_cnt_o), 32'd0);
    check("rst.empty", 32'(fifo_empty_o), 32'd1);
    check("rst.full", 32'(fifo_full_o), 32'd0);
    check("rst.fe", 32'(frame_err_o), 32'd0);
    check("rst.ovf", 32'(ovf_o), 32'd0);
    check("rst.err_cnt", 32'(err_cnt_o), 32'd0);

    // Error counter saturation over 300 bad frames.
    rx_data_t_i = 10'h3FF;
    for (int i = 1; i <= 300; i++) begin
      rx_data_en_i = 1'b1;
      tick();
      if (i == 254) check("sat.254", 32'(err_cnt_o), 32'hFE);
      if (i == 255) check("sat.255", 32'(err_cnt_o), 32'hFF);
    end
    rx_data_en_i = 1'b0;
    check("sat.300", 32'(err_cnt_o), 32'hFF);
    check("sat.fe", 32'(frame_err_o), 32'd1);
    check("sat.cnt", 32'(fifo_cnt_o), 32'd0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("clr.err_cnt", 32'(err_cnt_o), 32'd0);
    check("clr.fe", 32'(frame_err_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
